// File: rtl/irq_trap_ctrl_if.sv
// Pipeline/CSR side bundle of the machine-mode trap sequencer.
// The master side (pipeline + CSR file) drives the *_i members and
// consumes the *_o members; the sequencer itself sits on the slave side.
interface irq_trap_ctrl_if #(
   parameter int DATA_WIDTH = 32
);

   logic                  inst_valid_i;
   logic [DATA_WIDTH-1:0] pc_i;
   logic                  ecall_i;
   logic                  ebreak_i;
   logic                  mret_i;
   logic                  mstatus_ie_i;
   logic                  mie_external_i;
   logic                  mie_timer_i;
   logic                  mie_software_i;
   logic                  mip_external_i;
   logic                  mip_timer_i;
   logic                  mip_software_i;
   logic [DATA_WIDTH-1:0] mtvec_i;
   logic [DATA_WIDTH-1:0] mepc_i;

   logic                  epc_we_o;
   logic [DATA_WIDTH-1:0] epc_o;
   logic                  cause_we_o;
   logic [3:0]            cause_o;
   logic                  interrupt_type_o;
   logic                  mstatus_ie_clear_o;
   logic                  mstatus_ie_set_o;
   logic                  hold_o;
   logic                  flush_o;
   logic                  redirect_o;
   logic [DATA_WIDTH-1:0] redirect_pc_o;

   modport master (
      output inst_valid_i, pc_i, ecall_i, ebreak_i, mret_i,
      output mstatus_ie_i, mie_external_i, mie_timer_i, mie_software_i,
      output mip_external_i, mip_timer_i, mip_software_i, mtvec_i, mepc_i,
      input  epc_we_o, epc_o, cause_we_o, cause_o, interrupt_type_o,
      input  mstatus_ie_clear_o, mstatus_ie_set_o, hold_o, flush_o,
      input  redirect_o, redirect_pc_o
   );

   modport slave (
      input  inst_valid_i, pc_i, ecall_i, ebreak_i, mret_i,
      input  mstatus_ie_i, mie_external_i, mie_timer_i, mie_software_i,
      input  mip_external_i, mip_timer_i, mip_software_i, mtvec_i, mepc_i,
      output epc_we_o, epc_o, cause_we_o, cause_o, interrupt_type_o,
      output mstatus_ie_clear_o, mstatus_ie_set_o, hold_o, flush_o,
      output redirect_o, redirect_pc_o
   );

endinterface

// File: rtl/irq_trap_ctrl.sv
// Machine-mode trap sequencer. Watches the instruction at the commit point
// for ecall/ebreak/mret and for enabled pending interrupts, then walks the
// CSR file through mepc/mcause/mstatus updates and redirects fetch either to
// the mtvec handler or back to mepc.
module irq_trap_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter bit VECTORED_EN = 1'b1
) (
   input logic           clk_i,
   input logic           rst_i,
   irq_trap_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SAVE = 2'd1,
      JUMP = 2'd2,
      MRET = 2'd3
   } state_t;

   localparam logic [3:0] CAUSE_ECALL    = 4'd11;
   localparam logic [3:0] CAUSE_EBREAK   = 4'd3;
   localparam logic [3:0] CAUSE_EXTERNAL = 4'd11;
   localparam logic [3:0] CAUSE_SOFTWARE = 4'd3;
   localparam logic [3:0] CAUSE_TIMER    = 4'd7;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] pcCap_q, pcCap_d;
   logic [3:0]            causeCap_q, causeCap_d;
   logic                  typeCap_q, typeCap_d;

   logic                  irqExternal;
   logic                  irqSoftware;
   logic                  irqTimer;
   logic                  irqPend;
   logic                  evtTrap;
   logic                  evtMret;
   logic [3:0]            evtCause;
   logic                  evtType;
   logic                  take;

   logic [DATA_WIDTH-1:0] trapBase;
   logic [DATA_WIDTH-1:0] vectorOffset;
   logic                  useVectored;

   // Decode which event, if any, the commit-point instruction raises this
   // cycle; synchronous exceptions win over mret, which wins over interrupts.
   always_comb begin
      irqExternal = bus.mie_external_i & bus.mip_external_i;
      irqSoftware = bus.mie_software_i & bus.mip_software_i;
      irqTimer    = bus.mie_timer_i & bus.mip_timer_i;
      irqPend     = bus.mstatus_ie_i & (irqExternal | irqSoftware | irqTimer);

      evtTrap  = 1'b0;
      evtMret  = 1'b0;
      evtCause = 4'd0;
      evtType  = 1'b0;

      if (bus.inst_valid_i) begin
         if (bus.ecall_i) begin
            evtTrap  = 1'b1;
            evtCause = CAUSE_ECALL;
         end else if (bus.ebreak_i) begin
            evtTrap  = 1'b1;
            evtCause = CAUSE_EBREAK;
         end else if (bus.mret_i) begin
            evtMret = 1'b1;
         end else if (irqPend) begin
            evtTrap = 1'b1;
            evtType = 1'b1;
            if (irqExternal) begin
               evtCause = CAUSE_EXTERNAL;
            end else if (irqSoftware) begin
               evtCause = CAUSE_SOFTWARE;
            end else begin
               evtCause = CAUSE_TIMER;
            end
         end
      end

      take = (state_q == IDLE) & (evtTrap | evtMret);
   end

   // Handler address: mtvec base, plus 4*cause for interrupts when the
   // vectored mode is both compiled in and selected by mtvec[1:0].
   always_comb begin
      trapBase     = {bus.mtvec_i[DATA_WIDTH-1:2], 2'b00};
      vectorOffset = {{(DATA_WIDTH-6){1'b0}}, causeCap_q, 2'b00};
      useVectored  = VECTORED_EN & (bus.mtvec_i[1:0] == 2'b01) & typeCap_q;
   end

   // State and captured trap context; reset abandons any sequence in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         pcCap_q    <= '0;
         causeCap_q <= 4'd0;
         typeCap_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pcCap_q    <= pcCap_d;
         causeCap_q <= causeCap_d;
         typeCap_q  <= typeCap_d;
      end
   end

   // Next state and per-cycle strobes; the context is frozen once captured
   // so input changes during SAVE/JUMP cannot disturb the trap in progress.
   always_comb begin
      state_d    = state_q;
      pcCap_d    = pcCap_q;
      causeCap_d = causeCap_q;
      typeCap_d  = typeCap_q;

      bus.epc_we_o           = 1'b0;
      bus.epc_o              = '0;
      bus.cause_we_o         = 1'b0;
      bus.cause_o            = 4'd0;
      bus.interrupt_type_o   = 1'b0;
      bus.mstatus_ie_clear_o = 1'b0;
      bus.mstatus_ie_set_o   = 1'b0;
      bus.hold_o             = take | (state_q != IDLE);
      bus.flush_o            = 1'b0;
      bus.redirect_o         = 1'b0;
      bus.redirect_pc_o      = '0;

      case (state_q)
         IDLE: begin
            if (take && evtTrap) begin
               pcCap_d    = bus.pc_i;
               causeCap_d = evtCause;
               typeCap_d  = evtType;
               state_d    = SAVE;
            end else if (take && evtMret) begin
               state_d = MRET;
            end
         end
         SAVE: begin
            bus.epc_we_o           = 1'b1;
            bus.epc_o              = {pcCap_q[DATA_WIDTH-1:2], 2'b00};
            bus.cause_we_o         = 1'b1;
            bus.cause_o            = causeCap_q;
            bus.interrupt_type_o   = typeCap_q;
            bus.mstatus_ie_clear_o = 1'b1;
            state_d                = JUMP;
         end
         JUMP: begin
            bus.redirect_o    = 1'b1;
            bus.flush_o       = 1'b1;
            bus.redirect_pc_o = useVectored ? (trapBase + vectorOffset) : trapBase;
            state_d           = IDLE;
         end
         MRET: begin
            bus.mstatus_ie_set_o = 1'b1;
            bus.redirect_o       = 1'b1;
            bus.flush_o          = 1'b1;
            bus.redirect_pc_o    = bus.mepc_i;
            state_d              = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Bench for irq_trap_ctrl: directed scenarios followed by random traffic,
// all compared against a schedule-based reference model of the sequencer.
module tb_irq_trap_ctrl;

   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;

   irq_trap_ctrl_if #(.DATA_WIDTH(DW)) bus ();

   irq_trap_ctrl #(
      .DATA_WIDTH (DW),
      .VECTORED_EN(1'b1)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // One cycle of pipeline/CSR inputs; en/pend are ordered {ext, sw, timer}.
   typedef struct {
      logic          rst;
      logic          valid;
      logic [DW-1:0] pc;
      logic          ecall;
      logic          ebreak;
      logic          mret;
      logic          mie;
      logic [2:0]    en;
      logic [2:0]    pend;
      logic [DW-1:0] mtvec;
      logic [DW-1:0] mepc;
   } stim_t;

   // A future cycle the model has committed to: 1 = CSR save, 2 = jump to
   // handler, 3 = return to mepc.
   typedef struct {
      int         kind;
      logic [DW-1:0] pc;
      logic [3:0] cause;
      logic       typ;
   } step_t;

   step_t sched[$];
   int    checks   = 0;
   int    failures = 0;

   // Count one comparison and report it if it does not match.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic stim_t idleStim();
      stim_t s;
      s.rst    = 1'b0;
      s.valid  = 1'b0;
      s.pc     = '0;
      s.ecall  = 1'b0;
      s.ebreak = 1'b0;
      s.mret   = 1'b0;
      s.mie    = 1'b0;
      s.en     = 3'b000;
      s.pend   = 3'b000;
      s.mtvec  = '0;
      s.mepc   = '0;
      return s;
   endfunction

   task automatic driveInputs(input stim_t s);
      rst                = s.rst;
      bus.inst_valid_i   = s.valid;
      bus.pc_i           = s.pc;
      bus.ecall_i        = s.ecall;
      bus.ebreak_i       = s.ebreak;
      bus.mret_i         = s.mret;
      bus.mstatus_ie_i   = s.mie;
      bus.mie_external_i = s.en[2];
      bus.mie_software_i = s.en[1];
      bus.mie_timer_i    = s.en[0];
      bus.mip_external_i = s.pend[2];
      bus.mip_software_i = s.pend[1];
      bus.mip_timer_i    = s.pend[0];
      bus.mtvec_i        = s.mtvec;
      bus.mepc_i         = s.mepc;
   endtask

   // Drive one cycle of inputs, predict every output from the model, check,
   // and let the clock edge happen. Reset throws away any scheduled steps.
   task automatic applyStimulus(input stim_t s);
      step_t         cur;
      step_t         nxt;
      logic [2:0]    active;
      logic          eWe, cWe, typ, clr, set, hold, flush, redir;
      logic [DW-1:0] epc, rpc, base;
      logic [3:0]    cause;
      bit            trap, ret;

      @(negedge clk);
      driveInputs(s);
      #1;

      eWe = 0; cWe = 0; typ = 0; clr = 0; set = 0; hold = 0; flush = 0; redir = 0;
      epc = '0; rpc = '0; cause = 4'd0;

      if (sched.size() > 0) begin
         cur  = sched.pop_front();
         hold = 1;
         if (cur.kind == 1) begin
            eWe   = 1;
            epc   = cur.pc & ~32'd3;
            cWe   = 1;
            cause = cur.cause;
            typ   = cur.typ;
            clr   = 1;
         end else if (cur.kind == 2) begin
            redir = 1;
            flush = 1;
            base  = s.mtvec & ~32'd3;
            if (s.mtvec[1:0] == 2'b01 && cur.typ)
               rpc = base + 32'(cur.cause) * 32'd4;
            else
               rpc = base;
         end else begin
            set   = 1;
            redir = 1;
            flush = 1;
            rpc   = s.mepc;
         end
      end else if (s.valid) begin
         trap   = 0;
         ret    = 0;
         active = s.mie ? (s.en & s.pend) : 3'b000;
         nxt.pc = s.pc;
         nxt.typ = 0;
         nxt.cause = 4'd0;
         if (s.ecall) begin
            trap = 1; nxt.cause = 4'd11;
         end else if (s.ebreak) begin
            trap = 1; nxt.cause = 4'd3;
         end else if (s.mret) begin
            ret = 1;
         end else if (active != 3'b000) begin
            trap    = 1;
            nxt.typ = 1;
            nxt.cause = active[2] ? 4'd11 : (active[1] ? 4'd3 : 4'd7);
         end
         hold = trap | ret;
         if (!s.rst) begin
            if (trap) begin
               nxt.kind = 1; sched.push_back(nxt);
               nxt.kind = 2; sched.push_back(nxt);
            end else if (ret) begin
               nxt.kind = 3; sched.push_back(nxt);
            end
         end
      end

      if (s.rst) sched.delete();

      checkOutput("epc_we",      64'(bus.epc_we_o),           64'(eWe));
      checkOutput("epc",         64'(bus.epc_o),              64'(epc));
      checkOutput("cause_we",    64'(bus.cause_we_o),         64'(cWe));
      checkOutput("cause",       64'(bus.cause_o),            64'(cause));
      checkOutput("irq_type",    64'(bus.interrupt_type_o),   64'(typ));
      checkOutput("ie_clear",    64'(bus.mstatus_ie_clear_o), 64'(clr));
      checkOutput("ie_set",      64'(bus.mstatus_ie_set_o),   64'(set));
      checkOutput("hold",        64'(bus.hold_o),             64'(hold));
      checkOutput("flush",       64'(bus.flush_o),            64'(flush));
      checkOutput("redirect",    64'(bus.redirect_o),         64'(redir));
      checkOutput("redirect_pc", 64'(bus.redirect_pc_o),      64'(rpc));
   endtask

   // Directed scenarios, then randomized traffic with occasional resets.
   initial begin
      stim_t s;

      driveInputs(idleStim());
      rst = 1'b1;
      repeat (2) @(posedge clk);

      s = idleStim();
      s.rst = 1'b1;
      repeat (2) applyStimulus(s);

      $display("[TB] timer interrupt, direct mode");
      s = idleStim();
      s.valid = 1; s.pc = 32'h100; s.mie = 1; s.en = 3'b001; s.pend = 3'b001;
      s.mtvec = 32'h8000_0000;
      applyStimulus(s);
      s.mie = 0;
      repeat (3) applyStimulus(s);

      $display("[TB] vectored external over timer");
      s = idleStim();
      s.valid = 1; s.pc = 32'h300; s.mie = 1; s.en = 3'b101; s.pend = 3'b101;
      s.mtvec = 32'h8000_0001;
      applyStimulus(s);
      s.mie = 0;
      repeat (4) applyStimulus(s);

      $display("[TB] ecall with software pending, then back-to-back mret");
      s = idleStim();
      s.valid = 1; s.pc = 32'h204; s.ecall = 1; s.mie = 1; s.en = 3'b010; s.pend = 3'b010;
      s.mtvec = 32'h8000_0001;
      applyStimulus(s);
      s.ecall = 0; s.pc = 32'h999;
      repeat (2) applyStimulus(s);
      s = idleStim();
      s.valid = 1; s.mret = 1; s.mepc = 32'h104;
      applyStimulus(s);
      s.mret = 0; s.mepc = 32'h108;
      repeat (2) applyStimulus(s);

      $display("[TB] gating: MIE clear, then no valid instruction");
      s = idleStim();
      s.valid = 1; s.mie = 0; s.en = 3'b111; s.pend = 3'b111;
      repeat (10) applyStimulus(s);
      s.valid = 0; s.mie = 1; s.ecall = 1; s.mret = 1;
      repeat (10) applyStimulus(s);

      $display("[TB] reset during SAVE");
      s = idleStim();
      s.valid = 1; s.pc = 32'h440; s.ebreak = 1; s.mtvec = 32'h1000;
      applyStimulus(s);
      s = idleStim();
      s.rst = 1; s.mtvec = 32'h1000;
      applyStimulus(s);
      s.rst = 0;
      repeat (3) applyStimulus(s);

      $display("[TB] random traffic");
      for (int i = 0; i < 3000; i++) begin
         s.rst    = ($urandom_range(0, 59) == 0);
         s.valid  = ($urandom_range(0, 9) < 7);
         s.pc     = $urandom;
         s.ecall  = ($urandom_range(0, 9) == 0);
         s.ebreak = ($urandom_range(0, 9) == 0);
         s.mret   = ($urandom_range(0, 9) == 0);
         s.mie    = $urandom_range(0, 1);
         s.en     = 3'($urandom);
         s.pend   = 3'($urandom);
         s.mtvec  = ($urandom_range(0, 1) == 1) ? {$urandom_range(0, 32'hFFFF) , 14'd0, 2'b01}
                                                : $urandom;
         s.mepc   = $urandom;
         applyStimulus(s);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/irq_trap_ctrl.md
Name: irq_trap_ctrl

Overview:
- Machine-mode trap sequencer between the pipeline and the CSR file.
- Detects synchronous exceptions (ecall/ebreak), mret, and enabled pending interrupts (external/software/timer) on the instruction currently at the commit point.
- Drives CSR side-effects in a fixed cycle order: mepc write, mcause write, mstatus IE clear/set.
- Redirects and flushes the pipeline to the mtvec-derived handler address or back to mepc.

Parameters:
- DATA_WIDTH, 32, width of PC/CSR data paths.
- VECTORED_EN, 1, 1 = honour mtvec[1:0]==01 vectored mode; 0 = always direct mode.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- inst_valid_i  in  1  valid instruction at commit point.
- pc_i  in  DATA_WIDTH  PC of that instruction.
- ecall_i  in  1  commit instruction is ecall.
- ebreak_i  in  1  commit instruction is ebreak.
- mret_i  in  1  commit instruction is mret.
- mstatus_ie_i  in  1  mstatus.MIE.
- mie_external_i / mie_timer_i / mie_software_i  in  1 each  mie enable bits.
- mip_external_i / mip_timer_i / mip_software_i  in  1 each  pending lines.
- mtvec_i  in  DATA_WIDTH  mtvec.
- mepc_i  in  DATA_WIDTH  mepc.
- epc_we_o  out  1  mepc write strobe.
- epc_o  out  DATA_WIDTH  mepc write data.
- cause_we_o  out  1  mcause write strobe.
- cause_o  out  4  exception code.
- interrupt_type_o  out  1  1 = interrupt, 0 = exception.
- mstatus_ie_clear_o  out  1  clear MIE (MPIE<=MIE in CSR).
- mstatus_ie_set_o  out  1  restore MIE from MPIE.
- hold_o  out  1  pipeline must not retire or advance.
- flush_o  out  1  kill all in-flight instructions.
- redirect_o  out  1  load redirect_pc_o into fetch PC.
- redirect_pc_o  out  DATA_WIDTH  new PC.

Behaviour:
- Clock/reset: single clock clk_i; rst_i is synchronous and active-high.
- Reset:
  - state=IDLE; all registered outputs 0.
  - epc_o=0, cause_o=0, redirect_pc_o=0.
  - Reset mid-sequence aborts immediately: no further strobes. CSR writes already issued stand.
- Pending interrupt: irq_pend = mstatus_ie_i & ((mie_external_i&mip_external_i) | (mie_software_i&mip_software_i) | (mie_timer_i&mip_timer_i)).
- Interrupt priority: external (cause 11) > software (cause 3) > timer (cause 7).
- Event priority in IDLE with inst_valid_i=1: ecall (cause 11, type 0) > ebreak (cause 3, type 0) > mret > interrupt.
  - ecall_i, ebreak_i and mret_i are all gated by inst_valid_i.
  - inst_valid_i=0: nothing is taken.
- take = IDLE & event selected. hold_o = take | (state != IDLE), combinational.
- Trap path, with detect cycle T:
  - T: capture pc_i, cause, type into registers; next state SAVE.
  - T+1 SAVE:
    - epc_we_o=1, epc_o={pc_cap[31:2],2'b00}.
    - cause_we_o=1, cause_o=cause_cap, interrupt_type_o=type_cap.
    - mstatus_ie_clear_o=1.
    - Next state JUMP.
  - T+2 JUMP:
    - redirect_o=1, flush_o=1.
    - redirect_pc_o = {mtvec_i[31:2],2'b00}, or {mtvec_i[31:2],2'b00} + 4*cause_cap when VECTORED_EN=1 & mtvec_i[1:0]==01 & type_cap==1.
    - Address arithmetic wraps modulo 2^DATA_WIDTH.
    - Next state IDLE.
  - T+3: IDLE. New events are evaluated from this cycle.
- mret path:
  - T: next state MRET.
  - T+1 MRET: mstatus_ie_set_o=1, redirect_o=1, flush_o=1, redirect_pc_o=mepc_i sampled that cycle. Next state IDLE.
- Strobes are single-cycle pulses. Each cycle asserts at most one of mstatus_ie_clear_o / mstatus_ie_set_o.
- Interrupt lines are level-sensitive and not latched.
  - Changes outside IDLE are ignored.
  - Re-evaluated at return to IDLE; after a trap MIE is cleared, so no immediate re-entry.
- Cause/type/pc are frozen at T. Input changes during SAVE/JUMP do not alter them.
- Back-to-back: mret in the first IDLE cycle after JUMP is accepted (no dead cycle).

Test Plan:
- Timer interrupt: MIE=1, mie_timer=1, mip_timer=1, inst_valid, pc_i=0x100, mtvec=0x8000_0000 -> T+1: epc_we=1, epc_o=0x100, cause_o=7, interrupt_type=1, ie_clear=1; T+2: redirect_pc=0x8000_0000, flush=1.
- Vectored external: mtvec=0x8000_0001, external+timer both pending/enabled -> cause_o=11, redirect_pc=0x8000_002C; timer not taken on return (MIE=0).
- Simultaneous ecall + pending software irq, pc_i=0x204 -> cause_o=11, interrupt_type=0, epc_o=0x204, redirect_pc=mtvec base.
- mret with mepc_i=0x104 -> T+1: ie_set=1, redirect_o=1, redirect_pc=0x104, flush=1; no epc/cause strobes.
- Gating: MIE=0 with all pending, or inst_valid=0 -> no strobes, hold_o=0 for 10 cycles.
- rst_i asserted in SAVE cycle -> next cycle all outputs 0, state IDLE, no redirect issued.
